// File: rtl/obstacle_spawner.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_spawner
// Purpose  : Turns the game engine's 3-bit LFSR output into timed obstacle
//            spawn requests. It counts game ticks between spawns and draws a
//            lane from the random value, rejecting lanes that are out of range
//            or that repeat the previous lane. A fallback lane is used after
//            too many rejected draws. The lane is offered on a valid/ready
//            handshake. The LFSR is stepped only when a draw consumes its value.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            enable             - game running; low returns to IDLE
//            tick               - one-cycle game-tick pulse
//            interval[7:0]      - ticks between spawns, sampled on reload
//            rnd[2:0]           - current LFSR output
//            rnd_step           - LFSR clock enable (high only while drawing)
//            spawn_valid        - registered spawn request valid
//            spawn_lane[2:0]    - lane of the request
//            spawn_ready        - playfield accepts the request
//            spawn_count[15:0]  - accepted spawns, saturating
//            fallback_used      - one-cycle pulse when the fallback lane is used
// Revision : 1.0 - initial release
// ============================================================================
module obstacle_spawner #(
    parameter int NUM_LANES    = 5,
    parameter int MIN_INTERVAL = 4,
    parameter int MAX_DRAWS    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        tick,
    input  logic [7:0]  interval,
    input  logic [2:0]  rnd,
    output logic        rnd_step,
    output logic        spawn_valid,
    output logic [2:0]  spawn_lane,
    input  logic        spawn_ready,
    output logic [15:0] spawn_count,
    output logic        fallback_used
);

    localparam int                DRAW_W      = $clog2(MAX_DRAWS + 1);
    localparam logic [7:0]        C_MIN_IVL   = 8'(MIN_INTERVAL);
    localparam logic [3:0]        C_NUM_LANES = 4'(NUM_LANES);
    localparam logic [DRAW_W-1:0] C_MAX_DRAWS = DRAW_W'(MAX_DRAWS);
    localparam logic [2:0]        C_LANE_NONE = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DRAW  = 2'd2,
        S_OFFER = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [7:0]          cnt_q,       cnt_d;
    logic [DRAW_W-1:0]   draws_q,     draws_d;
    logic [2:0]          last_lane_q, last_lane_d;
    logic [2:0]          lane_q,      lane_d;
    logic                valid_q,     valid_d;
    logic [15:0]         count_q,     count_d;
    logic                fb_q,        fb_d;

    logic [7:0]          w_reload;
    logic                w_rnd_ok;
    logic [2:0]          w_fallback_lane;
    logic                w_last_draw;
    logic                w_handshake;
    logic [15:0]         w_count_inc;

    // Short intervals are clamped so spawns can never come back-to-back.
    assign w_reload    = (interval < C_MIN_IVL) ? C_MIN_IVL : interval;
    assign w_rnd_ok    = ({1'b0, rnd} < C_NUM_LANES) && (rnd != last_lane_q);
    assign w_last_draw = ((draws_q + DRAW_W'(1)) == C_MAX_DRAWS);
    assign w_handshake = valid_q && spawn_ready;
    assign w_count_inc = (count_q == 16'hFFFF) ? count_q : (count_q + 16'd1);

    // Fallback lane: the lane after the previous one (wrapping), or lane 0
    // when nothing has been spawned yet.
    always_comb begin
        w_fallback_lane = 3'd0;
        if ((last_lane_q != C_LANE_NONE) &&
            ({1'b0, last_lane_q} != (C_NUM_LANES - 4'd1))) begin
            w_fallback_lane = last_lane_q + 3'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        draws_d     = draws_q;
        last_lane_d = last_lane_q;
        lane_d      = lane_q;
        valid_d     = valid_q;
        count_d     = count_q;
        fb_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                draws_d = '0;
                if (enable) begin
                    cnt_d   = w_reload;
                    state_d = S_COUNT;
                end
            end

            S_COUNT: begin
                if (!enable) begin
                    draws_d = '0;
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (cnt_q <= 8'd1) begin
                        draws_d = '0;
                        state_d = S_DRAW;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            S_DRAW: begin
                if (!enable) begin
                    draws_d = '0;
                    state_d = S_IDLE;
                end else if (w_rnd_ok) begin
                    lane_d  = rnd;
                    valid_d = 1'b1;
                    draws_d = '0;
                    state_d = S_OFFER;
                end else if (w_last_draw) begin
                    // A stuck or hostile LFSR still yields a spawn here.
                    lane_d  = w_fallback_lane;
                    valid_d = 1'b1;
                    fb_d    = 1'b1;
                    draws_d = '0;
                    state_d = S_OFFER;
                end else begin
                    draws_d = draws_q + DRAW_W'(1);
                end
            end

            S_OFFER: begin
                // A handshake in the same cycle as enable=0 still completes.
                if (w_handshake) begin
                    count_d     = w_count_inc;
                    last_lane_d = lane_q;
                    cnt_d       = w_reload;
                    valid_d     = 1'b0;
                    state_d     = enable ? S_COUNT : S_IDLE;
                end else if (!enable) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                valid_d = 1'b0;
                draws_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            draws_q     <= '0;
            last_lane_q <= C_LANE_NONE;
            lane_q      <= 3'd0;
            valid_q     <= 1'b0;
            count_q     <= 16'd0;
            fb_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            draws_q     <= draws_d;
            last_lane_q <= last_lane_d;
            lane_q      <= lane_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            fb_q        <= fb_d;
        end
    end

    // The LFSR advances on the same edge that consumes its value.
    assign rnd_step      = (state_q == S_DRAW);
    assign spawn_valid   = valid_q;
    assign spawn_lane    = lane_q;
    assign spawn_count   = count_q;
    assign fallback_used = fb_q;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_spawner.sv
`default_nettype none
// ============================================================================
// Module   : tb_obstacle_spawner
// Purpose  : Self-checking bench for obstacle_spawner. The bench plays the
//            LFSR (a table of random values stepped by rnd_step), drives
//            ticks, enable and ready, and predicts spawns with a
//            transaction-level model. A monitor compares the DUT against
//            the predictions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obstacle_spawner;

    localparam int NL   = 5;
    localparam int MINI = 4;
    localparam int MAXD = 8;
    localparam int RS   = 8192;

    localparam int M_IDLE  = 0;
    localparam int M_COUNT = 1;
    localparam int M_DRAW  = 2;
    localparam int M_OFFER = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        tick = 1'b0;
    logic [7:0]  interval = 8'd0;
    logic [2:0]  rnd = 3'd0;
    logic        spawn_ready = 1'b0;
    logic        rnd_step;
    logic        spawn_valid;
    logic [2:0]  spawn_lane;
    logic [15:0] spawn_count;
    logic        fallback_used;

    obstacle_spawner #(
        .NUM_LANES   (NL),
        .MIN_INTERVAL(MINI),
        .MAX_DRAWS   (MAXD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .tick         (tick),
        .interval     (interval),
        .rnd          (rnd),
        .rnd_step     (rnd_step),
        .spawn_valid  (spawn_valid),
        .spawn_lane   (spawn_lane),
        .spawn_ready  (spawn_ready),
        .spawn_count  (spawn_count),
        .fallback_used(fallback_used)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int lane;
        int fb;
    } spawn_t;

    spawn_t exp_q[$];
    int     count_exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- LFSR emulation ----------------
    int rseq [RS];
    int rp        = 0;
    int step_prev = 0;

    // ---------------- reference model ----------------
    int m_mode, m_cnt, m_drawleft, m_last, m_lane, m_count;
    int exp_valid = 0;
    int exp_step  = 0;
    int mon_en    = 0;

    int d_en = 0, d_tk = 0, d_rdy = 0, d_ivl = 6;

    function automatic int clamp_ivl(input int ivl);
        return (ivl < MINI) ? MINI : ivl;
    endfunction

    // Scan the upcoming random values the way the spawn rules describe:
    // the first legal, non-repeating lane wins; after MAXD misses the
    // lane after the previous one is taken.
    task automatic resolve_draw(output int lane, output int fb, output int d);
        int found;
        int v;
        found = 0;
        fb    = 1;
        d     = MAXD;
        lane  = (m_last == 7) ? 0 : (m_last + 1) % NL;
        for (int i = 0; i < MAXD; i++) begin
            v = rseq[(rp + i) % RS];
            if (found == 0 && v < NL && v != m_last) begin
                found = 1;
                lane  = v;
                fb    = 0;
                d     = i + 1;
            end
        end
    endtask

    task automatic model_reset();
        m_mode     = M_IDLE;
        m_cnt      = 0;
        m_drawleft = 0;
        m_last     = 7;
        m_lane     = 0;
        m_count    = 0;
        exp_valid  = 0;
        exp_step   = 0;
        exp_q.delete();
        count_exp_q.delete();
    endtask

    // One clock cycle: drive inputs at the falling edge, publish what the
    // DUT should show during this cycle, then advance the model.
    task automatic cycle();
        int l, f, d;
        spawn_t e;
        @(negedge clk);
        if (step_prev != 0) rp = (rp + 1) % RS;
        rnd         = 3'(rseq[rp]);
        step_prev   = int'(rnd_step);
        enable      = d_en[0];
        tick        = d_tk[0];
        spawn_ready = d_rdy[0];
        interval    = 8'(d_ivl);
        exp_valid   = (m_mode == M_OFFER) ? 1 : 0;
        exp_step    = (m_mode == M_DRAW) ? 1 : 0;
        case (m_mode)
            M_IDLE: begin
                if (d_en != 0) begin
                    m_cnt  = clamp_ivl(d_ivl);
                    m_mode = M_COUNT;
                end
            end
            M_COUNT: begin
                if (d_en == 0) m_mode = M_IDLE;
                else if (d_tk != 0) begin
                    if (m_cnt == 1) begin
                        resolve_draw(l, f, d);
                        e.lane = l;
                        e.fb   = f;
                        exp_q.push_back(e);
                        m_lane     = l;
                        m_drawleft = d;
                        m_mode     = M_DRAW;
                    end else begin
                        m_cnt--;
                    end
                end
            end
            M_DRAW: begin
                if (d_en == 0) begin
                    void'(exp_q.pop_back());
                    m_mode = M_IDLE;
                end else begin
                    m_drawleft--;
                    if (m_drawleft == 0) m_mode = M_OFFER;
                end
            end
            default: begin
                if (d_rdy != 0) begin
                    if (m_count < 65535) m_count++;
                    count_exp_q.push_back(m_count);
                    m_last = m_lane;
                    m_cnt  = clamp_ivl(d_ivl);
                    m_mode = (d_en != 0) ? M_COUNT : M_IDLE;
                end else if (d_en == 0) begin
                    m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic run_until_count(input int target, input int budget, input int period);
        int k;
        k = 0;
        while (m_count < target && k < budget) begin
            d_tk = ((k % period) == (period - 1)) ? 1 : 0;
            cycle();
            k++;
        end
        d_tk = 0;
        if (m_count < target) chk("run_until_count_timeout", m_count, target);
    endtask

    task automatic wait_offer(input int budget);
        int k;
        k = 0;
        d_tk = 1;
        while (m_mode != M_OFFER && k < budget) begin
            cycle();
            k++;
        end
        d_tk = 0;
        if (m_mode != M_OFFER) chk("wait_offer_timeout", m_mode, M_OFFER);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_spawn_valid"},   int'(spawn_valid),   0);
        chk({tag, "_spawn_lane"},    int'(spawn_lane),    0);
        chk({tag, "_rnd_step"},      int'(rnd_step),      0);
        chk({tag, "_spawn_count"},   int'(spawn_count),   0);
        chk({tag, "_fallback_used"}, int'(fallback_used), 0);
    endtask

    // Reset asserted mid-cycle to show the outputs clear without a clock.
    task automatic do_reset_mid();
        #3;
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        d_en = 0; d_tk = 0; d_rdy = 0;
        enable = 1'b0; tick = 1'b0; spawn_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        step_prev = 0;
        model_reset();
        mon_en = 1;
    endtask

    // ---------------- monitor ----------------
    int     mon_pv   = 0;
    int     mon_pl   = 0;
    int     mon_pend = 0;
    spawn_t mon_e;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en == 0) begin
                mon_pv   = 0;
                mon_pend = 0;
            end else begin
                chk("spawn_valid", int'(spawn_valid), exp_valid);
                chk("rnd_step", int'(rnd_step), exp_step);
                if (mon_pend != 0) begin
                    if (count_exp_q.size() == 0) chk("spawn_count_unexpected", int'(spawn_count), -1);
                    else chk("spawn_count", int'(spawn_count), count_exp_q.pop_front());
                    mon_pend = 0;
                end
                if (spawn_valid && mon_pv == 0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_spawn_lane", int'(spawn_lane), -1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("spawn_lane", int'(spawn_lane), mon_e.lane);
                        chk("fallback_used", int'(fallback_used), mon_e.fb);
                    end
                end else begin
                    chk("fallback_idle", int'(fallback_used), 0);
                end
                if (spawn_valid && mon_pv != 0) chk("lane_stable", int'(spawn_lane), mon_pl);
                if (spawn_valid && spawn_ready) mon_pend = 1;
                mon_pv = int'(spawn_valid);
                mon_pl = int'(spawn_lane);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < RS; i++) rseq[i] = $urandom_range(0, 7);
        model_reset();

        // Power-on reset
        #2;
        rst_n = 1'b0;
        #1;
        @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;

        // interval 6, always ready, rnd 3 then 6 (rejected) then 1
        rseq[rp] = 3; rseq[(rp + 1) % RS] = 6; rseq[(rp + 2) % RS] = 1;
        d_ivl = 6; d_rdy = 1; d_en = 1;
        run_until_count(2, 200, 2);

        // short interval is clamped; rnd 5,7 rejected then 2
        d_ivl = 2;
        rseq[rp] = 5; rseq[(rp + 1) % RS] = 7; rseq[(rp + 2) % RS] = 2;
        run_until_count(3, 200, 1);

        // rnd stuck at the previous lane -> fallback to lane 3
        for (int i = 0; i < 10; i++) rseq[(rp + i) % RS] = 2;
        run_until_count(4, 200, 1);
        run_until_count(5, 200, 3);

        // backpressure: ready low for a dozen cycles while ticks arrive
        d_rdy = 0;
        wait_offer(200);
        for (int i = 0; i < 12; i++) begin
            d_tk = $urandom_range(0, 1);
            cycle();
        end
        d_tk = 0; d_rdy = 1;
        cycle();
        d_rdy = 0;
        repeat (3) cycle();

        // enable dropped during COUNT
        d_tk = 1;
        repeat (2) cycle();
        d_en = 0;
        cycle();
        d_en = 1;
        repeat (2) cycle();

        // enable dropped in OFFER without handshake (abort)
        wait_offer(200);
        cycle();
        d_en = 0;
        cycle();
        d_en = 1;
        repeat (2) cycle();

        // enable dropped together with ready in OFFER
        wait_offer(200);
        cycle();
        d_en = 0; d_rdy = 1;
        cycle();
        d_rdy = 0;
        repeat (2) cycle();
        d_en = 1;

        // reset while offering, then restart with a clamped interval
        wait_offer(200);
        cycle();
        do_reset_mid();
        d_ivl = 0; d_en = 1; d_rdy = 1;
        run_until_count(1, 200, 2);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if (m_mode == M_COUNT && $urandom_range(0, 19) == 0) begin
                int c;
                c = $urandom_range(0, 7);
                for (int i = 0; i < 10; i++) rseq[(rp + i) % RS] = c;
            end
            if ($urandom_range(0, 49) == 0) d_ivl = $urandom_range(0, 9);
            d_en  = ($urandom_range(0, 99) < 2) ? 0 : 1;
            d_tk  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            d_rdy = ($urandom_range(0, 3) != 0) ? 1 : 0;
            cycle();
        end

        // drain: disable so any in-flight draw or offer is abandoned
        d_en = 0; d_tk = 0; d_rdy = 0;
        repeat (3) cycle();
        @(negedge clk);
        #2;
        mon_en = 0;
        chk("spawns_outstanding", exp_q.size(), 0);
        chk("counts_outstanding", count_exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
Consumes the 3-bit pseudo-random value from the game engine's LFSR and turns it into timed obstacle spawn requests for the playfield logic. It counts game ticks between spawns, draws a lane from the random value (rejecting out-of-range or repeated lanes), and offers the lane on a valid/ready handshake. It also drives the LFSR's step enable, so the random source advances only when a draw consumes it.

Parameters:
NUM_LANES, 5, number of lanes; legal lanes are 0..NUM_LANES-1 (must be 1..8)
MIN_INTERVAL, 4, lower clamp on ticks between spawns
MAX_DRAWS, 8, rejected draws allowed before fallback lane selection

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  game running; low aborts or holds the spawner in IDLE
tick  input  1  one-cycle game-tick pulse
interval  input  8  ticks between spawns; sampled at each reload
rnd  input  3  current LFSR output
rnd_step  output  1  clock enable to the LFSR; steps it on the same clk edge
spawn_valid  output  1  spawn request valid
spawn_lane  output  3  lane of the request
spawn_ready  input  1  playfield accepts the request
spawn_count  output  16  accepted spawns, saturating at 16'hFFFF
fallback_used  output  1  one-cycle pulse when the fallback lane was taken

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; spawn_valid=0, spawn_lane=0, rnd_step=0, spawn_count=0, fallback_used=0; internal last_lane=3'b111 (none), tick counter=0, draw counter=0.
- States: IDLE, COUNT, DRAW, OFFER.
- IDLE: when enable=1, load cnt=max(interval, MIN_INTERVAL) and go to COUNT on the next edge.
- COUNT: each cycle with tick=1 decrements cnt. A tick with cnt==1 goes to DRAW with draws=0. Non-tick cycles hold cnt.
- DRAW: one attempt per clk cycle, and tick is ignored. rnd_step=1 in every DRAW cycle, so the next cycle sees a fresh rnd.
  - Accept when rnd<NUM_LANES and rnd!=last_lane: latch spawn_lane=rnd and go to OFFER.
  - Otherwise draws++. If draws reaches MAX_DRAWS, latch spawn_lane=(last_lane+1) mod NUM_LANES, or 0 when last_lane=none. Pulse fallback_used and go to OFFER.
  - Worst-case draw latency is MAX_DRAWS cycles.
- OFFER: spawn_valid=1 with spawn_lane held stable until the handshake. rnd_step=0.
  - On spawn_valid&&spawn_ready: spawn_count+=1 (saturating), last_lane=spawn_lane, reload cnt=max(interval, MIN_INTERVAL), go to COUNT.
  - Ticks during OFFER are discarded, so the interval restarts after acceptance.
- spawn_valid is registered. It rises on the first cycle of OFFER and falls the cycle after the handshake.
- enable=0 in any state: go to IDLE on the next edge, drop spawn_valid without a handshake (abort), clear the draw counter. last_lane and spawn_count are retained.
- Simultaneous enable=0 and handshake in OFFER: the handshake completes (count and last_lane update), then the block goes to IDLE.
- interval=0..MIN_INTERVAL-1 is clamped to MIN_INTERVAL. The interval input is not re-sampled mid-count.
- An LFSR stuck at a constant value (e.g. an all-zero lockup) cannot hang the block. The fallback path guarantees a spawn within MAX_DRAWS cycles.
- rnd_step is high only in DRAW. The LFSR does not advance in IDLE, COUNT or OFFER.

Test Plan:
- Reset mid-OFFER (spawn_valid=1) -> all outputs 0 asynchronously. After release with enable=1, the first spawn_valid appears only after 4 ticks.
- interval=6, spawn_ready=1, rnd sequence 3,6,... -> spawn_valid rises after the 6th tick with spawn_lane=3. spawn_count=1. The next spawn follows 6 ticks after the handshake.
- interval=2 -> the clamp applies and spawns come every 4 ticks. rnd=5,7,2 with NUM_LANES=5 -> rnd_step is high for 3 DRAW cycles, then spawn_lane=2.
- last_lane=2, rnd held constant at 2 -> 8 rejected draws, fallback_used pulses, spawn_lane=3.
- spawn_ready=0 for 10 cycles while ticks arrive -> spawn_valid and spawn_lane stay stable, rnd_step=0 and spawn_count stays unchanged. Raising spawn_ready gives exactly one increment.
- enable dropped during COUNT and during OFFER -> IDLE next cycle and spawn_valid=0. enable=0 together with spawn_ready=1 in OFFER -> spawn_count increments, then IDLE.
